// File: rtl/mux_pkg.sv
// Shared definitions for the synchronous N-channel mux: FSM state encoding
// and a bit-count helper used for toggle accounting.
package mux_pkg;

  typedef enum logic [1:0] {
    DESCONECTADO  = 2'd0,
    CONECTANDO    = 2'd1,
    CONECTADO     = 2'd2,
    DESCONECTANDO = 2'd3
  } state_t;

  // Widest channel the popcount helper accepts; callers zero-extend into it.
  localparam int POP_MAX_W = 256;

  function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c = c + 9'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mux_sinc_n_contador_conmutaciones.sv
// Saturating accumulator of output bit toggles with a sticky saturation flag;
// a clear request wins over the increment of the same cycle.
module contador_conmutaciones #(
  parameter int CNT_W = 16,
  parameter int INC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W:0]   w_sum;

  // One extra bit so a carry out marks overflow.
  assign w_sum = {1'b0, r_cnt} + (CNT_W+1)'(inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_sum[CNT_W]) begin
      r_cnt <= '1;
      r_sat <= 1'b1;
    end else begin
      r_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/mux_sinc_n.sv
// Clocked 1-of-N multiplexer with active-low output enable, modelled
// connect/disconnect latency and switching-activity counter.
module mux_sinc_n
  import mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int EN_LAT   = 2,
  parameter int DIS_LAT  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic                      notoe,
  input  logic                      clr_cnt,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [CNT_W-1:0]          toggles,
  output logic                      sat
);

  localparam int INC_W   = $clog2(WIDTH + 1);
  localparam int LAT_MAX = (EN_LAT > DIS_LAT) ? EN_LAT : DIS_LAT;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int N_SLOTS = 2 ** SEL_W;

  localparam logic [LAT_W-1:0] EN_LOAD     = LAT_W'(EN_LAT - 1);
  localparam logic [LAT_W-1:0] DIS_LOAD    = LAT_W'(DIS_LAT - 1);
  localparam logic [SEL_W:0]   CH_LIMIT    = (SEL_W+1)'(CHANNELS);
  localparam logic [INC_W-1:0] LOAD_CHARGE = INC_W'(WIDTH);

  state_t           r_state;
  logic [LAT_W-1:0] r_lat;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_drive;

  logic [WIDTH-1:0] w_ch [N_SLOTS];
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_y_next;
  logic [INC_W-1:0] w_pop;
  logic [INC_W-1:0] w_inc;

  // Select codes beyond CHANNELS hit zero padding, but are masked by w_sel_ok.
  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_ch
      if (gi < CHANNELS) begin : g_real
        assign w_ch[gi] = a[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_ch[gi] = '0;
      end
    end
  endgenerate

  assign w_sel_ok = ({1'b0, sel} < CH_LIMIT);
  assign w_y_next = w_sel_ok ? w_ch[sel] : r_y;
  assign w_pop    = INC_W'(popcount(POP_MAX_W'(w_y_next ^ r_y)));

  always_comb begin
    w_inc = '0;
    case (r_state)
      CONECTANDO:    if (!notoe && r_lat == '0) w_inc = LOAD_CHARGE;
      CONECTADO:     if (!notoe) w_inc = w_pop;
      DESCONECTANDO: if (r_lat == '0) w_inc = LOAD_CHARGE;
      default:       w_inc = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DESCONECTADO;
      r_lat   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_drive <= 1'b0;
    end else begin
      case (r_state)
        DESCONECTADO: begin
          if (!notoe) begin
            r_state <= CONECTANDO;
            r_lat   <= EN_LOAD;
          end
        end
        CONECTANDO: begin
          if (notoe) begin
            r_state <= DESCONECTADO;
          end else if (r_lat == '0) begin
            r_state <= CONECTADO;
            r_y     <= w_y_next;
            r_valid <= 1'b1;
            r_drive <= 1'b1;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        CONECTADO: begin
          if (notoe) begin
            r_state <= DESCONECTANDO;
            r_lat   <= DIS_LOAD;
            r_valid <= 1'b0;
          end else begin
            r_y <= w_y_next;
          end
        end
        DESCONECTANDO: begin
          // Release is committed: notoe is not looked at until the bus is let go.
          if (r_lat == '0) begin
            r_state <= DESCONECTADO;
            r_drive <= 1'b0;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        default: r_state <= DESCONECTADO;
      endcase
    end
  end

  assign y       = r_drive ? r_y : {WIDTH{1'bz}};
  assign y_valid = r_valid;

  contador_conmutaciones #(
    .CNT_W (CNT_W),
    .INC_W (INC_W)
  ) u_contador (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (w_inc),
    .cnt   (toggles),
    .sat   (sat)
  );

endmodule
